// File: rtl/irq_arbiter.sv
// irq_arbiter: edge-detecting, maskable, round-robin interrupt controller
// between memory-mapped devices and cp0. The pending/ack, mask and cause
// registers sit on the data address space. After a source is taken, no
// further interrupt is taken until ERET.
module irq_arbiter #(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned ID_W       = 2,
    parameter logic [31:0] ACK_ADDR   = 32'hffff0070,
    parameter logic [31:0] MASK_ADDR  = 32'hffff0074,
    parameter logic [31:0] CAUSE_ADDR = 32'hffff0078
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               global_en,
    input  logic               eret,
    input  logic [31:0]        address,
    input  logic [31:0]        wr_data,
    input  logic               MemRead,
    input  logic               MemWrite,
    output logic [31:0]        rd_data,
    output logic               IrqAddress,
    output logic               TakenInterrupt,
    output logic [ID_W-1:0]    cause_id,
    output logic               in_handler
);

    localparam int unsigned    DATA_W  = 32;
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_SRC - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        HANDLER = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] irq_prev;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] eligible;
    logic               any_eligible;

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    win_id;
    logic [ID_W-1:0]    win_hi;
    logic [ID_W-1:0]    win_lo;
    logic               found_hi;

    logic               hit_ack;
    logic               hit_mask;
    logic               hit_cause;
    logic               unused_wr_hi;

    // Register address decode; independent of the read/write strobes.
    assign hit_ack    = (address == ACK_ADDR);
    assign hit_mask   = (address == MASK_ADDR);
    assign hit_cause  = (address == CAUSE_ADDR);
    assign IrqAddress = hit_ack | hit_mask | hit_cause;

    // A request is recorded once, on its rising edge; a held level does not re-arm it.
    assign rise = irq_in & ~irq_prev;

    // Write-1-to-clear acknowledge from the handler.
    assign clr = (MemWrite && hit_ack) ? wr_data[NUM_SRC-1:0] : '0;

    // Masking only gates arbitration; masked sources stay pending.
    assign eligible     = pending & mask;
    assign any_eligible = |eligible;

    assign in_handler = (state == HANDLER);

    // Store data above the source count has no register behind it.
    assign unused_wr_hi = ^wr_data[DATA_W-1:NUM_SRC];

    // Round-robin pick: lowest eligible index at or above rr_ptr, otherwise wrap
    // to the lowest eligible index overall.
    always_comb begin
        win_hi   = '0;
        win_lo   = '0;
        found_hi = 1'b0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_lo = ID_W'(i);
                if (ID_W'(i) >= rr_ptr) begin
                    win_hi   = ID_W'(i);
                    found_hi = 1'b1;
                end
            end
        end
        win_id = found_hi ? win_hi : win_lo;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and interrupt-taken strobe; ERET only matters in HANDLER.
    always_comb begin
        state_next     = state;
        TakenInterrupt = 1'b0;
        case (state)
            IDLE: begin
                TakenInterrupt = global_en & any_eligible;
                if (TakenInterrupt) begin
                    state_next = HANDLER;
                end
            end
            HANDLER: begin
                if (eret) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Edge history, pending set/clear (set wins), mask, and the serviced-source record.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_prev <= '0;
            pending  <= '0;
            mask     <= '1;
            rr_ptr   <= '0;
            cause_id <= '0;
        end else begin
            irq_prev <= irq_in;
            pending  <= (pending & ~clr) | rise;
            if (MemWrite && hit_mask) begin
                mask <= wr_data[NUM_SRC-1:0];
            end
            if (TakenInterrupt) begin
                cause_id <= win_id;
                rr_ptr   <= (win_id == LAST_ID) ? '0 : win_id + ID_W'(1);
            end
        end
    end

    // Combinational load data; zero unless a load targets one of the registers.
    always_comb begin
        rd_data = '0;
        if (MemRead) begin
            if (hit_ack) begin
                rd_data = DATA_W'(pending);
            end else if (hit_mask) begin
                rd_data = DATA_W'(mask);
            end else if (hit_cause) begin
                rd_data             = DATA_W'(cause_id);
                rd_data[DATA_W-1]   = in_handler;
            end
        end
    end

endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter: directed walk through the controller's scenarios followed by
// random traffic, all compared against a behavioural model of the controller.
module tb_irq_arbiter;

    localparam int unsigned N    = 4;
    localparam int unsigned IDW  = 2;
    localparam logic [31:0] ACK  = 32'hffff0070;
    localparam logic [31:0] MSK  = 32'hffff0074;
    localparam logic [31:0] CAU  = 32'hffff0078;
    localparam logic [31:0] OTHR = 32'h10010000;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   irq_in;
    logic           global_en;
    logic           eret;
    logic [31:0]    address;
    logic [31:0]    wr_data;
    logic           MemRead;
    logic           MemWrite;
    logic [31:0]    rd_data;
    logic           IrqAddress;
    logic           TakenInterrupt;
    logic [IDW-1:0] cause_id;
    logic           in_handler;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    bit m_pend [N];
    bit m_mask [N];
    bit m_prev [N];
    bit m_hand;
    int m_cause;
    int m_rr;

    irq_arbiter #(
        .NUM_SRC(N), .ID_W(IDW),
        .ACK_ADDR(ACK), .MASK_ADDR(MSK), .CAUSE_ADDR(CAU)
    ) dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .global_en(global_en),
        .eret(eret), .address(address), .wr_data(wr_data),
        .MemRead(MemRead), .MemWrite(MemWrite), .rd_data(rd_data),
        .IrqAddress(IrqAddress), .TakenInterrupt(TakenInterrupt),
        .cause_id(cause_id), .in_handler(in_handler)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0;
            m_mask[i] = 1'b1;
            m_prev[i] = 1'b0;
        end
        m_hand  = 1'b0;
        m_cause = 0;
        m_rr    = 0;
    endtask

    // First pending-and-unmasked source met when walking upward from m_rr.
    function automatic int m_winner();
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_rr + k) % N;
            if (m_pend[idx] && m_mask[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic bit m_taken();
        return global_en && !m_hand && (m_winner() >= 0);
    endfunction

    function automatic bit m_irqaddr();
        return (address == ACK) || (address == MSK) || (address == CAU);
    endfunction

    function automatic logic [31:0] m_rd();
        logic [31:0] r;
        r = 32'h0;
        if (!MemRead) return r;
        if (address == ACK) begin
            for (int i = 0; i < N; i++) if (m_pend[i]) r = r + (32'd1 << i);
        end else if (address == MSK) begin
            for (int i = 0; i < N; i++) if (m_mask[i]) r = r + (32'd1 << i);
        end else if (address == CAU) begin
            r = 32'(m_cause) + (m_hand ? 32'h80000000 : 32'h0);
        end
        return r;
    endfunction

    // One clock: compare combinational outputs, advance model and DUT, compare registered outputs.
    task automatic cycle();
        bit nxt [N];
        bit take;
        int w;
        #1;
        check("taken", 32'(TakenInterrupt), 32'(m_taken()));
        check("irq_address", 32'(IrqAddress), 32'(m_irqaddr()));
        check("rd_data", rd_data, m_rd());
        take = m_taken();
        w    = m_winner();
        for (int i = 0; i < N; i++) begin
            bit rs;
            bit cl;
            rs = irq_in[i] && !m_prev[i];
            cl = MemWrite && (address == ACK) && wr_data[i];
            nxt[i] = (m_pend[i] && !cl) || rs;
        end
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            m_pend[i] = nxt[i];
            m_prev[i] = irq_in[i];
            if (MemWrite && (address == MSK)) m_mask[i] = wr_data[i];
        end
        if (!m_hand) begin
            if (take) begin
                m_hand  = 1'b1;
                m_cause = w;
                m_rr    = (w + 1) % N;
            end
        end else if (eret) begin
            m_hand = 1'b0;
        end
        #1;
        check("in_handler", 32'(in_handler), 32'(m_hand));
        check("cause_id", 32'(cause_id), 32'(m_cause));
        @(negedge clk);
    endtask

    task automatic bus_idle();
        MemRead = 1'b0; MemWrite = 1'b0; address = 32'h0; wr_data = 32'h0;
    endtask

    task automatic load(input logic [31:0] a);
        MemRead = 1'b1; MemWrite = 1'b0; address = a; wr_data = 32'h0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        MemRead = 1'b0; MemWrite = 1'b1; address = a; wr_data = d;
    endtask

    initial begin
        reset = 1'b1; irq_in = '0; global_en = 1'b0; eret = 1'b0;
        bus_idle();
        m_reset();
        repeat (2) @(negedge clk);

        // Reset state.
        load(MSK);
        #1;
        check("reset_in_handler", 32'(in_handler), 32'h0);
        check("reset_cause", 32'(cause_id), 32'h0);
        check("reset_taken", 32'(TakenInterrupt), 32'h0);
        check("reset_mask_read", rd_data, 32'hF);
        @(negedge clk);
        reset = 1'b0; global_en = 1'b1; bus_idle();
        cycle();

        // Rise on source 0, held for several cycles.
        irq_in = 4'b0001; cycle();
        load(ACK); #1;
        check("first_pending", rd_data, 32'h1);
        check("first_taken", 32'(TakenInterrupt), 32'h1);
        cycle();
        check("first_handler", 32'(in_handler), 32'h1);
        check("first_cause", 32'(cause_id), 32'h0);
        repeat (3) begin
            load(ACK); #1;
            check("held_no_retake", 32'(TakenInterrupt), 32'h0);
            check("held_pending_once", rd_data, 32'h1);
            cycle();
        end

        // New request while servicing, ack of source 0, ERET latency.
        irq_in = 4'b0101; bus_idle(); cycle();
        load(ACK); #1;
        check("handler_pending", rd_data, 32'h5);
        check("handler_no_take", 32'(TakenInterrupt), 32'h0);
        cycle();
        store(ACK, 32'h1); cycle();
        load(ACK); #1;
        check("after_ack", rd_data, 32'h4);
        cycle();
        bus_idle(); eret = 1'b1; #1;
        check("eret_cycle_no_take", 32'(TakenInterrupt), 32'h0);
        cycle();
        eret = 1'b0; #1;
        check("post_eret_take", 32'(TakenInterrupt), 32'h1);
        cycle();
        check("post_eret_cause", 32'(cause_id), 32'h2);

        // Round robin from pointer 1 with pending 1001.
        store(ACK, 32'h4); irq_in = 4'b0000; cycle();
        bus_idle(); eret = 1'b1; cycle();
        eret = 1'b0; irq_in = 4'b0001; cycle();
        cycle();
        check("rr_setup_cause", 32'(cause_id), 32'h0);
        store(ACK, 32'h1); irq_in = 4'b0000; cycle();
        bus_idle(); irq_in = 4'b1001; cycle();
        eret = 1'b1; cycle();
        eret = 1'b0; #1;
        check("rr_take", 32'(TakenInterrupt), 32'h1);
        cycle();
        check("rr_winner3", 32'(cause_id), 32'h3);
        load(CAU); #1;
        check("cause_read", rd_data, 32'h80000003);
        cycle();
        bus_idle(); eret = 1'b1; cycle();
        eret = 1'b0; cycle();
        check("rr_wrap_winner0", 32'(cause_id), 32'h0);

        // Mask holds off a pending source until unmasked.
        store(ACK, 32'hF); irq_in = 4'b0000; cycle();
        bus_idle(); irq_in = 4'b0010; cycle();
        store(MSK, 32'h0); cycle();
        bus_idle(); eret = 1'b1; cycle();
        eret = 1'b0; #1;
        check("masked_no_take", 32'(TakenInterrupt), 32'h0);
        cycle();
        store(MSK, 32'hF); #1;
        check("mask_write_cycle", 32'(TakenInterrupt), 32'h0);
        cycle();
        bus_idle(); #1;
        check("unmasked_take", 32'(TakenInterrupt), 32'h1);
        cycle();
        check("unmasked_cause", 32'(cause_id), 32'h1);

        // Same-edge ack and rise: set wins.
        irq_in = 4'b0000; cycle();
        irq_in = 4'b0010; store(ACK, 32'h2); cycle();
        load(ACK); #1;
        check("set_wins", rd_data, 32'h2);
        cycle();

        // Global enable off.
        bus_idle(); eret = 1'b1; cycle();
        eret = 1'b0; global_en = 1'b0;
        repeat (2) begin
            #1;
            check("global_off", 32'(TakenInterrupt), 32'h0);
            cycle();
        end
        global_en = 1'b1; cycle();
        check("reenter_handler", 32'(in_handler), 32'h1);

        // Asynchronous reset between edges while in HANDLER.
        load(ACK);
        #3;
        reset = 1'b1;
        #1;
        m_reset();
        check("async_in_handler", 32'(in_handler), 32'h0);
        check("async_pending", rd_data, 32'h0);
        check("async_taken", 32'(TakenInterrupt), 32'h0);
        address = MSK; #1;
        check("async_mask", rd_data, 32'hF);
        store(OTHR, 32'hFFFFFFFF); #1;
        check("other_irqaddr", 32'(IrqAddress), 32'h0);
        check("other_rd", rd_data, 32'h0);
        @(negedge clk);
        reset = 1'b0; bus_idle();
        #1;
        check("post_reset_no_take", 32'(TakenInterrupt), 32'h0);
        cycle();
        cycle();

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            int op;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) irq_in[i] = ~irq_in[i];
            end
            global_en = ($urandom_range(0, 7) != 0);
            eret      = ($urandom_range(0, 3) == 0);
            op        = $urandom_range(0, 9);
            case (op)
                0, 1: load(ACK);
                2:    load(MSK);
                3:    load(CAU);
                4:    store(ACK, $urandom);
                5:    store(MSK, $urandom | 32'h0000_0003);
                6:    store(CAU, $urandom);
                7:    load(OTHR + 32'($urandom_range(0, 63)) * 32'd4);
                default: bus_idle();
            endcase
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
